// File: rtl/sync_mem.sv
`default_nettype none
// ============================================================================
//  Module   : sync_mem
//  Purpose  : Single-clock RAM with byte-lane writes, a registered read port,
//             a power-on clearing sweep and out-of-range error pulses.
//             Define SYNC_MEM_BYPASS_EN to forward same-cycle write data to
//             a read of the same address.
//  Revision : 1.0  initial release
// ============================================================================
module sync_mem #(
    parameter int ADDR_LEN  = 5,
    parameter int WORD_SIZE = 32,
    parameter int MEM_SIZE  = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   r_en,
    input  logic [ADDR_LEN-1:0]    r_addr,
    input  logic                   w_en,
    input  logic [ADDR_LEN-1:0]    w_addr,
    input  logic [WORD_SIZE-1:0]   data_in,
    input  logic [WORD_SIZE/8-1:0] w_be,
    output logic                   ready,
    output logic [WORD_SIZE-1:0]   data_out,
    output logic                   r_valid,
    output logic                   err
);

    localparam int                 c_LANES   = WORD_SIZE / 8;
    localparam logic [0:0]         c_ST_INIT = 1'b0;
    localparam logic [0:0]         c_ST_IDLE = 1'b1;
    localparam logic [ADDR_LEN-1:0] c_LAST   = ADDR_LEN'(MEM_SIZE - 1);

    logic [0:0]           r_state;
    logic [ADDR_LEN-1:0]  r_ptr;
    logic [WORD_SIZE-1:0] r_mem [MEM_SIZE];
    logic [WORD_SIZE-1:0] r_data;
    logic                 r_rd_valid;
    logic                 r_err;

    logic                 w_ready;
    logic                 w_rd_acc;
    logic                 w_wr_acc;
    logic                 w_rd_in_range;
    logic                 w_wr_in_range;
    logic [WORD_SIZE-1:0] w_old;
    logic [WORD_SIZE-1:0] w_merge;
    logic [WORD_SIZE-1:0] w_rd_word;

    assign w_ready  = (r_state == c_ST_IDLE);
    assign w_rd_acc = r_en & w_ready;
    assign w_wr_acc = w_en & w_ready;

    // A fully populated address space can never go out of range.
    generate
        if (MEM_SIZE == (1 << ADDR_LEN)) begin : g_full
            assign w_rd_in_range = 1'b1;
            assign w_wr_in_range = 1'b1;
        end else begin : g_partial
            assign w_rd_in_range = (32'(r_addr) < MEM_SIZE);
            assign w_wr_in_range = (32'(w_addr) < MEM_SIZE);
        end
    endgenerate

    assign w_old = r_mem[w_addr];

    generate
        for (genvar i = 0; i < c_LANES; i++) begin : g_lane
            assign w_merge[8*i +: 8] = w_be[i] ? data_in[8*i +: 8] : w_old[8*i +: 8];
        end
    endgenerate

    always_comb begin
        w_rd_word = r_mem[r_addr];
`ifdef SYNC_MEM_BYPASS_EN
        if (w_wr_acc && w_wr_in_range && (w_addr == r_addr)) begin
            w_rd_word = w_merge;
        end
`endif
    end

    // Array has no reset; the INIT sweep is the only clearing mechanism.
    always_ff @(posedge clk) begin
        if (r_state == c_ST_INIT) begin
            r_mem[r_ptr] <= '0;
        end else if (w_wr_acc && w_wr_in_range) begin
            r_mem[w_addr] <= w_merge;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_ST_INIT;
            r_ptr      <= '0;
            r_data     <= '0;
            r_rd_valid <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            r_err      <= (w_rd_acc & ~w_rd_in_range) | (w_wr_acc & ~w_wr_in_range);
            if (w_rd_acc) begin
                r_data <= w_rd_in_range ? w_rd_word : '0;
            end
            if (r_state == c_ST_INIT) begin
                r_ptr <= r_ptr + ADDR_LEN'(1);
                if (r_ptr == c_LAST) begin
                    r_state <= c_ST_IDLE;
                end
            end
        end
    end

    assign ready    = w_ready;
    assign data_out = r_data;
    assign r_valid  = r_rd_valid;
    assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sync_mem.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sync_mem
//  Purpose  : Scoreboard bench for sync_mem, one 32-word and one 20-word copy.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sync_mem;

    typedef struct packed {
        logic        rd;
        logic [31:0] d;
        logic        e;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst_n = 1'b1, b_rst_n = 1'b1;
    logic        a_r_en = 0, a_w_en = 0, b_r_en = 0, b_w_en = 0;
    logic [4:0]  a_r_addr = 0, a_w_addr = 0, b_r_addr = 0, b_w_addr = 0;
    logic [31:0] a_din = 0, b_din = 0;
    logic [3:0]  a_be = 0, b_be = 0;
    logic        a_ready, a_r_valid, a_err, b_ready, b_r_valid, b_err;
    logic [31:0] a_data_out, b_data_out;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t qa[$];
    exp_t qb[$];

    sync_mem #(.ADDR_LEN(5), .WORD_SIZE(32), .MEM_SIZE(32)) dut_a (
        .clk(clk), .rst_n(a_rst_n), .r_en(a_r_en), .r_addr(a_r_addr),
        .w_en(a_w_en), .w_addr(a_w_addr), .data_in(a_din), .w_be(a_be),
        .ready(a_ready), .data_out(a_data_out), .r_valid(a_r_valid), .err(a_err)
    );

    sync_mem #(.ADDR_LEN(5), .WORD_SIZE(32), .MEM_SIZE(20)) dut_b (
        .clk(clk), .rst_n(b_rst_n), .r_en(b_r_en), .r_addr(b_r_addr),
        .w_en(b_w_en), .w_addr(b_w_addr), .data_in(b_din), .w_be(b_be),
        .ready(b_ready), .data_out(b_data_out), .r_valid(b_r_valid), .err(b_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one request cycle; queue the hand-computed response if one is due.
    task automatic issue(input bit sel, input logic ren, input logic [4:0] ra,
                         input logic wen, input logic [4:0] wa, input logic [31:0] din,
                         input logic [3:0] be, input bit ev, input bit rd,
                         input logic [31:0] ed, input logic ee);
        exp_t x;
        x.rd = rd; x.d = ed; x.e = ee;
        if (sel == 1'b0) begin
            a_r_en = ren; a_r_addr = ra; a_w_en = wen; a_w_addr = wa; a_din = din; a_be = be;
            if (ev) qa.push_back(x);
        end else begin
            b_r_en = ren; b_r_addr = ra; b_w_en = wen; b_w_addr = wa; b_din = din; b_be = be;
            if (ev) qb.push_back(x);
        end
        @(posedge clk); #1;
        a_r_en = 0; a_w_en = 0; b_r_en = 0; b_w_en = 0;
    endtask

    task automatic wait_ready_a(output int n);
        n = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (a_ready) begin
                n = i;
                break;
            end
        end
    endtask

    always @(negedge clk) begin
        if (a_r_valid || a_err) begin
            exp_t e;
            n_checks++;
            if (qa.size() == 0) begin
                n_fail++;
                $display("FAIL a_unexpected: got r_valid=%b err=%b data=%h expected no event",
                         a_r_valid, a_err, a_data_out);
            end else begin
                e = qa.pop_front();
                if (a_r_valid !== e.rd || a_err !== e.e || (e.rd && a_data_out !== e.d)) begin
                    n_fail++;
                    $display("FAIL a_event: got r_valid=%b err=%b data=%h expected r_valid=%b err=%b data=%h",
                             a_r_valid, a_err, a_data_out, e.rd, e.e, e.d);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (b_r_valid || b_err) begin
            exp_t e;
            n_checks++;
            if (qb.size() == 0) begin
                n_fail++;
                $display("FAIL b_unexpected: got r_valid=%b err=%b data=%h expected no event",
                         b_r_valid, b_err, b_data_out);
            end else begin
                e = qb.pop_front();
                if (b_r_valid !== e.rd || b_err !== e.e || (e.rd && b_data_out !== e.d)) begin
                    n_fail++;
                    $display("FAIL b_event: got r_valid=%b err=%b data=%h expected r_valid=%b err=%b data=%h",
                             b_r_valid, b_err, b_data_out, e.rd, e.e, e.d);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ca, cb, n;
        logic [31:0] byp;
`ifdef SYNC_MEM_BYPASS_EN
        byp = 32'h1111AAAA;
`else
        byp = 32'h11111111;
`endif
        #2;
        a_rst_n = 0; b_rst_n = 0;
        #1;
        chk("reset_ready", {31'd0, a_ready}, 32'd0);
        chk("reset_outputs", {30'd0, a_r_valid, a_err}, 32'd0);
        chk("reset_data", a_data_out, 32'd0);
        @(posedge clk); @(posedge clk); #1;

        // Reads requested throughout INIT must be ignored.
        a_r_en = 1; a_r_addr = 5'd3; b_r_en = 1; b_r_addr = 5'd3;
        a_rst_n = 1; b_rst_n = 1;
        ca = 0; cb = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (a_ready && ca == 0) begin ca = i; a_r_en = 0; end
            if (b_ready && cb == 0) begin cb = i; b_r_en = 0; end
            if (ca != 0 && cb != 0) break;
        end
        chk("init_cycles_32", ca, 32);
        chk("init_cycles_20", cb, 20);

        for (int i = 0; i < 32; i++) issue(0, 1, 5'(i), 0, 0, 0, 0, 1, 1, 32'h0, 0);

        issue(0, 0, 0, 1, 5'd5, 32'hDEADBEEF, 4'b1111, 0, 0, 0, 0);
        issue(0, 0, 0, 1, 5'd5, 32'h00000011, 4'b0001, 0, 0, 0, 0);
        issue(0, 1, 5'd5, 0, 0, 0, 0, 1, 1, 32'hDEADBE11, 0);
        issue(0, 0, 0, 1, 5'd5, 32'hFFFFFFFF, 4'b0000, 0, 0, 0, 0);
        issue(0, 1, 5'd5, 0, 0, 0, 0, 1, 1, 32'hDEADBE11, 0);
        issue(0, 0, 0, 1, 5'd6, 32'h12345678, 4'b1010, 0, 0, 0, 0);
        issue(0, 1, 5'd6, 0, 0, 0, 0, 1, 1, 32'h12005600, 0);

        issue(0, 0, 0, 1, 5'd7, 32'h11111111, 4'b1111, 0, 0, 0, 0);
        issue(0, 1, 5'd7, 1, 5'd7, 32'hAAAAAAAA, 4'b0011, 1, 1, byp, 0);
        issue(0, 1, 5'd7, 0, 0, 0, 0, 1, 1, 32'h1111AAAA, 0);
        issue(0, 1, 5'd5, 1, 5'd9, 32'h000000FF, 4'b1111, 1, 1, 32'hDEADBE11, 0);
        issue(0, 1, 5'd9, 0, 0, 0, 0, 1, 1, 32'h000000FF, 0);

        issue(1, 0, 0, 1, 5'd25, 32'hCAFEF00D, 4'b1111, 1, 0, 0, 1);
        issue(1, 1, 5'd25, 0, 0, 0, 0, 1, 1, 32'h0, 1);
        issue(1, 1, 5'd5, 0, 0, 0, 0, 1, 1, 32'h0, 0);
        issue(1, 1, 5'd30, 1, 5'd31, 32'h12345678, 4'b1111, 1, 1, 32'h0, 1);
        issue(1, 0, 0, 1, 5'd4, 32'h00000055, 4'b1111, 0, 0, 0, 0);
        issue(1, 1, 5'd4, 0, 0, 0, 0, 1, 1, 32'h00000055, 0);

        // Reset mid-operation, then again during cycle 10 of INIT.
        a_rst_n = 0; #1;
        chk("midop_reset_data", a_data_out, 32'd0);
        chk("midop_reset_ready", {31'd0, a_ready}, 32'd0);
        @(posedge clk); #1;
        a_rst_n = 1;
        repeat (10) @(posedge clk);
        #1;
        a_rst_n = 0; #1;
        chk("midinit_reset_ready", {31'd0, a_ready}, 32'd0);
        @(posedge clk); #1;
        a_rst_n = 1;
        wait_ready_a(n);
        chk("reinit_cycles", n, 32);
        issue(0, 1, 5'd5, 0, 0, 0, 0, 1, 1, 32'h0, 0);
        issue(0, 1, 5'd7, 0, 0, 0, 0, 1, 1, 32'h0, 0);
        issue(0, 1, 5'd31, 0, 0, 0, 0, 1, 1, 32'h0, 0);

        // Reset one cycle after an accepted read discards the result.
        issue(0, 0, 0, 1, 5'd5, 32'h5A5A5A5A, 4'b1111, 0, 0, 0, 0);
        a_r_en = 1; a_r_addr = 5'd5;
        @(posedge clk); #1;
        a_r_en = 0; a_rst_n = 0; #1;
        chk("rdflight_reset_valid", {31'd0, a_r_valid}, 32'd0);
        chk("rdflight_reset_data", a_data_out, 32'd0);
        @(posedge clk); #1;
        a_rst_n = 1;
        wait_ready_a(n);
        chk("reinit2_cycles", n, 32);
        issue(0, 1, 5'd5, 0, 0, 0, 0, 1, 1, 32'h0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("a_queue_drained", qa.size(), 0);
        chk("b_queue_drained", qb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
